mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory-access stage of the five-stage MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. Issues word loads/stores to the data memory over a request/address-ok/data-ok handshake and stalls the pipeline while an access is outstanding. Selects the write-back value: the ALU result, or the loaded word.

## Interface
- DATA_WIDTH, default `INSTR_WIDTH (32): data and address width.
- clk  in  1  single pipeline clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_res_i  in  DATA_WIDTH  EX/MEM ALU result; the memory byte address for loads/stores.
- rt_data_i  in  DATA_WIDTH  EX/MEM store data.
- rd_i  in  5  destination register.
- mem_r_i  in  1  load instruction.
- w_mem_ena_i  in  1  store instruction.
- w_reg_ena_i  in  1  register write enable.
- wb_sel_i  in  1  1 = write back the loaded word, 0 = write back the ALU result.
- pc_i  in  32  debug PC.
- dreq_o  out  1  data-memory request.
- dwr_o  out  1  1 = write, 0 = read.
- daddr_o  out  DATA_WIDTH  word address sent to memory.
- dwdata_o  out  DATA_WIDTH  write data (rt_data_i).
- daddr_ok_i  in  1  memory accepted the request.
- ddata_ok_i  in  1  read data valid, or write completed.
- drdata_i  in  DATA_WIDTH  read data.
- wb_data_o  out  DATA_WIDTH  value to MEM/WB.
- rd_o  out  5  passthrough of rd_i.
- w_reg_ena_o  out  1  gated write enable to MEM/WB.
- pc_o  out  32  passthrough of pc_i.
- stall_o  out  1  hold request to the hazard unit; drives EX/MEM en (active = hold) and bubbles MEM/WB.
- addr_err_o  out  1  misaligned access; only with MEM_ALIGN_CHECK_EN, otherwise tied 0.

## Operation
- mem_op = mem_r_i | w_mem_ena_i.
- Non-memory op: pure passthrough; wb_data_o = alu_res_i; stall_o = 0; no request issued.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE with mem_op: go to REQ.
  - REQ: dreq_o = 1. On daddr_ok_i go to WAIT; if ddata_ok_i is also high in the same cycle, go straight to DONE.
  - WAIT: dreq_o = 0. On ddata_ok_i go to DONE.
  - DONE: go to IDLE unconditionally.
- IDLE→REQ is combinational: in the first cycle of a mem_op in IDLE, dreq_o = 1 already and the REQ transition rules apply in that cycle.
- Read data: drdata_i is captured into rdata_q on the cycle ddata_ok_i is high during a load.
- stall_o = 1 whenever mem_op is present and the state is not DONE.
- In DONE: stall_o = 0, so EX/MEM advances at the end of the DONE cycle and the access is never re-issued.
- Write-back value: wb_data_o = (wb_sel_i & mem_r_i) ? rdata_q : alu_res_i.
- w_reg_ena_o = w_reg_ena_i & ~stall_o, so no partial write-back enters MEM/WB.
- Memory-side outputs:
  - dwr_o = w_mem_ena_i.
  - daddr_o = {alu_res_i[31:2], 2'b00}.
  - dwdata_o = rt_data_i.
- ddata_ok_i or daddr_ok_i outside REQ/WAIT is ignored.

## Timing
- Reset (async): state = IDLE, rdata_q = 0.
  - Combined with the reset EX/MEM contents: dreq_o = 0, stall_o = 0, wb_data_o = 0, w_reg_ena_o = 0, addr_err_o = 0.
- Minimum memory-op latency: 2 cycles (REQ with same-cycle addr_ok and data_ok, then DONE). The stall lasts 1 cycle.
- General case: stall cycles = cycles to addr_ok + cycles to data_ok, where a same-cycle data_ok adds 0.
- Non-memory ops: 0 added latency.
- dreq_o is held high and its payload held stable until daddr_ok_i.
- Reset mid-access returns the FSM to IDLE immediately; any in-flight memory response after reset is ignored.

## Configuration
- MEM_ALIGN_CHECK_EN defined: a mem_op with alu_res_i[1:0] != 0:
  - issues no request (dreq_o = 0);
  - asserts addr_err_o combinationally for the single cycle the op occupies;
  - forces w_reg_ena_o = 0 and stall_o = 0.
- MEM_ALIGN_CHECK_EN undefined: the low address bits are silently dropped and addr_err_o is constant 0.

## Structure
- FSM state encodings (`MEM_ST_IDLE/REQ/WAIT/DONE, 2 bits) and `INSTR_WIDTH go in the shared defines.v.
- rdata_q reuses the existing FlopEnRC flop: en = load data capture, clear tied 0.
- One new sub-module is natural: mem_req_fsm, holding the state register and next-state/dreq/stall decode. The datapath muxing stays in the top.

## Test plan
- ADD, alu_res=0x0000_0010, w_reg_ena=1 → wb_data_o=0x10, stall_o=0, dreq_o never high.
- LW at 0x100, addr_ok and data_ok both in the first cycle, drdata=0xDEAD_BEEF → stall_o high 1 cycle, DONE cycle shows wb_data_o=0xDEADBEEF with w_reg_ena_o=1.
- SW at 0x104, rt_data=0x1234_5678, addr_ok after 2 cycles, data_ok 3 cycles later → dreq_o high 3 cycles with dwr_o=1 and stable payload, stall_o high 6 cycles, w_reg_ena_o=0 throughout.
- LW with data_ok 4 cycles after addr_ok, rst asserted in the WAIT state → FSM goes to IDLE asynchronously, stall_o=0, the late data_ok is ignored and rdata_q stays 0.
- With MEM_ALIGN_CHECK_EN: LW at 0x102 → addr_err_o=1 for one cycle, dreq_o=0, w_reg_ena_o=0. Without the macro → daddr_o=0x100 and a normal access.
- Back-to-back LW, LW → two full request sequences, with an IDLE→REQ re-entry right after DONE and no duplicate request for the first load.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants for the MEM stage: datapath width and request FSM state encodings.
package mem_stage_lsu_pkg;

    localparam int INSTR_WIDTH = 32;

    typedef logic [1:0] mem_state_t;

    localparam logic [1:0] MEM_ST_IDLE = 2'd0;
    localparam logic [1:0] MEM_ST_REQ  = 2'd1;
    localparam logic [1:0] MEM_ST_WAIT = 2'd2;
    localparam logic [1:0] MEM_ST_DONE = 2'd3;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Handshake: dreq_o is a valid that stays high with daddr_o/dwr_o/dwdata_o stable until
// daddr_ok_i (ready) is seen in the same cycle; ddata_ok_i is a completion strobe that
// only counts once the request has been accepted (same cycle or later).
interface mem_stage_lsu_if #(
    parameter int DATA_WIDTH = mem_stage_lsu_pkg::INSTR_WIDTH
);
    logic                  dreq_o;
    logic                  dwr_o;
    logic [DATA_WIDTH-1:0] daddr_o;
    logic [DATA_WIDTH-1:0] dwdata_o;
    logic                  daddr_ok_i;
    logic                  ddata_ok_i;
    logic [DATA_WIDTH-1:0] drdata_i;

    modport master (
        output dreq_o, dwr_o, daddr_o, dwdata_o,
        input  daddr_ok_i, ddata_ok_i, drdata_i
    );

    modport slave (
        input  dreq_o, dwr_o, daddr_o, dwdata_o,
        output daddr_ok_i, ddata_ok_i, drdata_i
    );
endinterface

// File: rtl/mem_stage_lsu_mem_req_fsm.sv
// Request sequencer for the MEM stage: state register plus next-state, dreq and stall decode.
module mem_stage_lsu_mem_req_fsm
    import mem_stage_lsu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_op,
    input  logic       addr_ok,
    input  logic       data_ok,
    output logic       dreq,
    output logic       stall,
    output logic       data_done,
    output mem_state_t state
);

    mem_state_t state_q;
    mem_state_t state_d;

    // IDLE with a pending op behaves exactly like REQ so the request goes out in the first cycle.
    always_comb begin
        state_d   = state_q;
        dreq      = 1'b0;
        data_done = 1'b0;
        case (state_q)
            MEM_ST_IDLE, MEM_ST_REQ: begin
                if (mem_op || (state_q == MEM_ST_REQ)) begin
                    dreq = 1'b1;
                    if (addr_ok) begin
                        if (data_ok) begin
                            state_d   = MEM_ST_DONE;
                            data_done = 1'b1;
                        end else begin
                            state_d = MEM_ST_WAIT;
                        end
                    end else begin
                        state_d = MEM_ST_REQ;
                    end
                end
            end
            MEM_ST_WAIT: begin
                if (data_ok) begin
                    state_d   = MEM_ST_DONE;
                    data_done = 1'b1;
                end
            end
            MEM_ST_DONE: state_d = MEM_ST_IDLE;
            default:     state_d = MEM_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MEM_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE releases the stall so EX/MEM advances and the access is not re-issued.
    assign stall = mem_op & (state_q != MEM_ST_DONE);
    assign state = state_q;

endmodule

// File: rtl/mem_stage_lsu.sv
// MIPS MEM stage: issues word loads/stores, stalls while outstanding, selects the write-back value.
// Optional build macro: MEM_ALIGN_CHECK_EN (reject misaligned loads/stores with addr_err_o).
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = INSTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] alu_res_i,
    input  logic [DATA_WIDTH-1:0] rt_data_i,
    input  logic [4:0]            rd_i,
    input  logic                  mem_r_i,
    input  logic                  w_mem_ena_i,
    input  logic                  w_reg_ena_i,
    input  logic                  wb_sel_i,
    input  logic [31:0]           pc_i,
    mem_stage_lsu_if.master       dmem,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [4:0]            rd_o,
    output logic                  w_reg_ena_o,
    output logic [31:0]           pc_o,
    output logic                  stall_o,
    output logic                  addr_err_o,
    output mem_state_t            dbg_state_o
);

    logic                  mem_op;
    logic                  misaligned;
    logic                  issue_op;
    logic                  dreq;
    logic                  stall;
    logic                  data_done;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign mem_op = mem_r_i | w_mem_ena_i;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op & (alu_res_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A rejected access never reaches the sequencer, so it neither requests nor stalls.
    assign issue_op = mem_op & ~misaligned;

    mem_stage_lsu_mem_req_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .mem_op    (issue_op),
        .addr_ok   (dmem.daddr_ok_i),
        .data_ok   (dmem.ddata_ok_i),
        .dreq      (dreq),
        .stall     (stall),
        .data_done (data_done),
        .state     (dbg_state_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (data_done & mem_r_i) begin
            rdata_q <= dmem.drdata_i;
        end
    end

    assign dmem.dreq_o   = dreq;
    assign dmem.dwr_o    = w_mem_ena_i;
    assign dmem.daddr_o  = {alu_res_i[DATA_WIDTH-1:2], 2'b00};
    assign dmem.dwdata_o = rt_data_i;

    assign wb_data_o   = (wb_sel_i & mem_r_i) ? rdata_q : alu_res_i;
    assign rd_o        = rd_i;
    assign pc_o        = pc_i;
    assign stall_o     = stall;
    assign w_reg_ena_o = w_reg_ena_i & ~stall & ~misaligned;
    assign addr_err_o  = misaligned;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed test-plan cases plus random ops against a cycle-count model.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] alu_res_i, rt_data_i, wb_data_o;
  logic [4:0]   rd_i, rd_o;
  logic         mem_r_i, w_mem_ena_i, w_reg_ena_i, wb_sel_i;
  logic [31:0]  pc_i, pc_o;
  logic         w_reg_ena_o, stall_o, addr_err_o;
  mem_state_t   dbg_state_o;

  mem_stage_lsu_if #(.DATA_WIDTH(W)) dmem ();

  mem_stage_lsu #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_res_i   (alu_res_i),
    .rt_data_i   (rt_data_i),
    .rd_i        (rd_i),
    .mem_r_i     (mem_r_i),
    .w_mem_ena_i (w_mem_ena_i),
    .w_reg_ena_i (w_reg_ena_i),
    .wb_sel_i    (wb_sel_i),
    .pc_i        (pc_i),
    .dmem        (dmem),
    .wb_data_o   (wb_data_o),
    .rd_o        (rd_o),
    .w_reg_ena_o (w_reg_ena_o),
    .pc_o        (pc_o),
    .stall_o     (stall_o),
    .addr_err_o  (addr_err_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_rdata;
  logic         chk_en = 1'b0;
  logic         first_cyc, last_cyc;
  logic         e_dreq, e_stall, e_wen, e_err, e_dwr;
  logic [W-1:0] e_daddr, e_dwdata;
  logic [4:0]   e_rd;
  logic [31:0]  e_pc;
  int           obs_stall, obs_dreq, obs_wen, obs_err;
  logic [W-1:0] obs_last_wb, obs_first_daddr;
  logic         obs_last_wen;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      checkb("dreq", dmem.dreq_o, e_dreq);
      checkb("stall", stall_o, e_stall);
      checkb("w_reg_ena", w_reg_ena_o, e_wen);
      checkb("addr_err", addr_err_o, e_err);
      checkb("dwr", dmem.dwr_o, e_dwr);
      check("daddr", dmem.daddr_o, e_daddr);
      check("dwdata", dmem.dwdata_o, e_dwdata);
      check("rd", W'(rd_o), W'(e_rd));
      check("pc", pc_o, e_pc);
      if (exp_q.size() == 0) begin
        check("wb_queue_empty", 32'd1, 32'd0);
      end else begin
        check("wb_data", wb_data_o, exp_q.pop_front());
      end
      if (stall_o)     obs_stall++;
      if (dmem.dreq_o) obs_dreq++;
      if (w_reg_ena_o) obs_wen++;
      if (addr_err_o)  obs_err++;
      if (first_cyc)   obs_first_daddr = dmem.daddr_o;
      if (last_cyc) begin
        obs_last_wb  = wb_data_o;
        obs_last_wen = w_reg_ena_o;
      end
    end
  end

  // ---------------- driver ----------------
  // One instruction held in EX/MEM for as long as the model says the stage stalls.
  // a = extra cycles before addr_ok, d = cycles from addr_ok to data_ok (0 = same cycle).
  task automatic run_op(input logic is_ld, input logic is_st, input logic wsel, input logic wen,
                        input logic [W-1:0] alu, input logic [W-1:0] rt, input logic [4:0] rd,
                        input logic [31:0] pc, input int a, input int d, input logic [W-1:0] rdata);
    logic act, mis, resp;
    int   n;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (is_ld | is_st) && (alu[1:0] != 2'b00);
`endif
    act = (is_ld | is_st) && !mis;
    n   = act ? a + d + 2 : 1;
    obs_stall = 0; obs_dreq = 0; obs_wen = 0; obs_err = 0;
    for (int k = 0; k < n; k++) begin
      mem_r_i = is_ld; w_mem_ena_i = is_st; wb_sel_i = wsel; w_reg_ena_i = wen;
      alu_res_i = alu; rt_data_i = rt; rd_i = rd; pc_i = pc;
      resp = act && (k < n - 1);
      // Outside an outstanding access the ok lines carry noise that must be ignored.
      dmem.daddr_ok_i = resp ? (k == a)     : 1'($urandom_range(0, 1));
      dmem.ddata_ok_i = resp ? (k == a + d) : 1'($urandom_range(0, 1));
      dmem.drdata_i   = (resp && is_ld && k == a + d) ? rdata : $urandom;
      e_stall  = act && (k < n - 1);
      e_dreq   = act && (k <= a);
      e_wen    = wen && !e_stall && !mis;
      e_err    = mis;
      e_dwr    = is_st;
      e_daddr  = {alu[W-1:2], 2'b00};
      e_dwdata = rt;
      e_rd     = rd;
      e_pc     = pc;
      first_cyc = (k == 0);
      last_cyc  = (k == n - 1);
      exp_q.push_back((wsel && is_ld) ? model_rdata : alu);
      chk_en = 1'b1;
      @(posedge clk); #1;
      if (resp && is_ld && k == a + d) model_rdata = rdata;
    end
  endtask

  task automatic zero_inputs();
    mem_r_i = 1'b0; w_mem_ena_i = 1'b0; wb_sel_i = 1'b0; w_reg_ena_i = 1'b0;
    alu_res_i = '0; rt_data_i = '0; rd_i = '0; pc_i = '0;
    dmem.daddr_ok_i = 1'b0; dmem.ddata_ok_i = 1'b0; dmem.drdata_i = '0;
  endtask

  task automatic run_random(input int count);
    int kind;
    logic [W-1:0] alu;
    for (int i = 0; i < count; i++) begin
      kind = $urandom_range(0, 9);
      alu  = $urandom;
      if ($urandom_range(0, 4) != 0) alu[1:0] = 2'b00;
      run_op(kind >= 4 && kind < 7, kind >= 7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             alu, $urandom, 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 4), $urandom);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    zero_inputs();
    model_rdata = '0;
    first_cyc = 1'b0;
    last_cyc  = 1'b0;
    #12;
    checkb("reset_dreq", dmem.dreq_o, 1'b0);
    checkb("reset_stall", stall_o, 1'b0);
    check("reset_wb_data", wb_data_o, 32'h0);
    checkb("reset_w_reg_ena", w_reg_ena_o, 1'b0);
    checkb("reset_addr_err", addr_err_o, 1'b0);
    check("reset_state", W'(dbg_state_o), W'(MEM_ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD: pure passthrough
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h5555_AAAA, 5'd3, 32'h0000_0400, 0, 0, '0);
    check("add_wb", obs_last_wb, 32'h0000_0010);
    check("add_dreq_cycles", obs_dreq, 0);
    check("add_stall_cycles", obs_stall, 0);
    checkb("add_w_reg_ena", obs_last_wen, 1'b1);

    // LW at 0x100, fastest memory response
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd8, 32'h0000_0404, 0, 0, 32'hDEAD_BEEF);
    check("lw_stall_cycles", obs_stall, 1);
    check("lw_done_wb", obs_last_wb, 32'hDEAD_BEEF);
    checkb("lw_done_w_reg_ena", obs_last_wen, 1'b1);

    // SW at 0x104, addr_ok after 2 cycles, data_ok 3 cycles later
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h1234_5678, 5'd0, 32'h0000_0408, 2, 3, '0);
    check("sw_dreq_cycles", obs_dreq, 3);
    check("sw_stall_cycles", obs_stall, 6);
    check("sw_w_reg_ena_cycles", obs_wen, 0);

    // LW at 0x102: rejected with the alignment check, word-aligned silently otherwise
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 5'd9, 32'h0000_040C, 1, 1, 32'hCAFE_F00D);
`ifdef MEM_ALIGN_CHECK_EN
    check("misalign_err_cycles", obs_err, 1);
    check("misalign_dreq_cycles", obs_dreq, 0);
    check("misalign_w_reg_ena_cycles", obs_wen, 0);
`else
    check("misalign_daddr", obs_first_daddr, 32'h0000_0100);
    check("misalign_err_cycles", obs_err, 0);
    check("misalign_dreq_cycles", obs_dreq, 2);
`endif

    // Back-to-back loads: second request must start right after the first DONE
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0, 5'd10, 32'h0000_0410, 1, 0, 32'h1111_2222);
    check("b2b_lw1_dreq_cycles", obs_dreq, 2);
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0204, 32'h0, 5'd11, 32'h0000_0414, 0, 2, 32'h3333_4444);
    check("b2b_lw2_dreq_cycles", obs_dreq, 1);
    check("b2b_lw2_wb", obs_last_wb, 32'h3333_4444);

    run_random(150);

    // Reset while a load waits for data; the late response must be ignored
    chk_en = 1'b0;
    mem_r_i = 1'b1; wb_sel_i = 1'b1; w_reg_ena_i = 1'b1; alu_res_i = 32'h0000_0300;
    dmem.daddr_ok_i = 1'b1; dmem.ddata_ok_i = 1'b0;
    @(posedge clk); #1;
    dmem.daddr_ok_i = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_state", W'(dbg_state_o), W'(MEM_ST_WAIT));
    #2 rst = 1'b1;
    #1 check("mid_reset_state", W'(dbg_state_o), W'(MEM_ST_IDLE));
    zero_inputs();
    model_rdata = '0;
    #1;
    checkb("mid_reset_stall", stall_o, 1'b0);
    checkb("mid_reset_dreq", dmem.dreq_o, 1'b0);
    check("mid_reset_wb", wb_data_o, 32'h0);
    checkb("mid_reset_w_reg_ena", w_reg_ena_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dmem.ddata_ok_i = 1'b1; dmem.drdata_i = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    dmem.ddata_ok_i = 1'b0;
    checkb("post_reset_stall", stall_o, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0308, 32'h0, 5'd12, 32'h0000_0500, 1, 0, 32'h7777_8888);
    check("post_reset_lw_wb", obs_last_wb, 32'h7777_8888);

    run_random(40);
    chk_en = 1'b0;
    if (exp_q.size() != 0) check("wb_queue_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
